// File: rtl/router_inj_pkg.sv
// Shared definitions for the router local-injection arbiter: flit layout, flow-control
// bit positions and FSM state encoding.
package router_inj_pkg;

    localparam int unsigned FLIT_W    = 68;
    localparam int unsigned DATA_W    = 64;

    localparam int unsigned VALID_BIT = 67;
    localparam int unsigned HEAD_BIT  = 66;
    localparam int unsigned TAIL_BIT  = 65;
    localparam int unsigned VC_BIT    = 64;

    localparam int unsigned FC_VALID_BIT = 1;
    localparam int unsigned FC_VC_BIT    = 0;

    typedef enum logic {
        StIdle,
        StLocked
    } inj_state_e;

endpackage

// File: rtl/rr_arbiter_pick.sv
// Combinational round-robin pick: first set bit of eligible_i at or after ptr_i, wrapping.
// Returns a one-hot grant, its index and whether anything was picked.
module rr_arbiter_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    eligible_i,
    input  logic [IdxW-1:0] ptr_i,
    output logic [N-1:0]    grant_o,
    output logic [IdxW-1:0] idx_o,
    output logic            valid_o
);

    always_comb begin
        int unsigned j;
        j       = 0;
        grant_o = '0;
        idx_o   = '0;
        valid_o = 1'b0;
        for (int unsigned k = 0; k < N; k++) begin
            j = (int'(ptr_i) + k) % N;
            if (!valid_o && eligible_i[j]) begin
                valid_o    = 1'b1;
                grant_o[j] = 1'b1;
                idx_o      = IdxW'(j);
            end
        end
    end

endmodule

// File: rtl/router_inject_arbiter.sv
// Packet-atomic round-robin arbiter sharing one router injection channel with per-VC credits.
// Optional stall watchdog on the locked owner: define ROUTER_INJ_WDOG_EN.
module router_inject_arbiter
    import router_inj_pkg::*;
#(
    parameter int unsigned NumReq   = 4,
    parameter int unsigned NumVc    = 2,
    parameter int unsigned BufDepth = 8,
    parameter int unsigned DataW    = 64
`ifdef ROUTER_INJ_WDOG_EN
    ,
    parameter int unsigned WdogCyc  = 255
`endif
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [NumReq-1:0]       req_valid_i,
    input  logic [NumReq-1:0]       req_head_i,
    input  logic [NumReq-1:0]       req_tail_i,
    input  logic [NumReq-1:0]       req_vc_i,
    input  logic [NumReq*DataW-1:0] req_data_i,
    output logic [NumReq-1:0]       req_ready_o,
    output logic [FLIT_W-1:0]       channel_out_o,
    input  logic [1:0]              flow_ctrl_i,
    output logic                    error_o
);

    localparam int unsigned IdxW = (NumReq > 1) ? $clog2(NumReq) : 1;
    localparam int unsigned CW   = $clog2(BufDepth + 1);

    inj_state_e              state_q, state_d;
    logic [IdxW-1:0]         owner_q, owner_d;
    logic                    owner_vc_q, owner_vc_d;
    logic [IdxW-1:0]         rr_ptr_q, rr_ptr_d;
    logic [NumVc-1:0][CW-1:0] credit_q, credit_d;
    logic [FLIT_W-1:0]       chan_q, chan_d;
    logic                    error_q, error_d;

    logic [NumReq-1:0]       eligible, pick_grant;
    logic [IdxW-1:0]         pick_idx, xfer_idx;
    logic                    pick_valid, xfer, xfer_vc, xfer_head, xfer_tail;
    logic [NumVc-1:0]        cr_inc, cr_dec;
    logic                    overflow, wdog_hit;

    always_comb begin
        for (int unsigned i = 0; i < NumReq; i++) begin
            eligible[i] = req_valid_i[i] & req_head_i[i] & (credit_q[req_vc_i[i]] != '0);
        end
    end

    rr_arbiter_pick #(
        .N    (NumReq),
        .IdxW (IdxW)
    ) u_pick (
        .eligible_i (eligible),
        .ptr_i      (rr_ptr_q),
        .grant_o    (pick_grant),
        .idx_o      (pick_idx),
        .valid_o    (pick_valid)
    );

    // Ready is forced low while reset is held so nothing looks accepted mid-reset.
    always_comb begin
        req_ready_o = '0;
        xfer_idx    = '0;
        xfer_vc     = 1'b0;
        if (!reset) begin
            unique case (state_q)
                StIdle: begin
                    if (pick_valid) begin
                        req_ready_o = pick_grant;
                        xfer_idx    = pick_idx;
                        xfer_vc     = req_vc_i[pick_idx];
                    end
                end
                StLocked: begin
                    xfer_idx = owner_q;
                    xfer_vc  = owner_vc_q;
                    if (req_valid_i[owner_q] && credit_q[owner_vc_q] != '0) begin
                        req_ready_o[owner_q] = 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    assign xfer      = |req_ready_o;
    assign xfer_head = req_head_i[xfer_idx];
    assign xfer_tail = req_tail_i[xfer_idx];

`ifdef ROUTER_INJ_WDOG_EN
    localparam int unsigned WdW = ($clog2(WdogCyc + 1) > 8) ? $clog2(WdogCyc + 1) : 8;
    logic [WdW-1:0] wdog_q, wdog_d;

    // Only an absent owner counts; credit stalls with the owner still valid do not.
    always_comb begin
        wdog_d   = wdog_q;
        wdog_hit = 1'b0;
        if (state_q == StIdle || xfer) begin
            wdog_d = '0;
        end else if (!req_valid_i[owner_q]) begin
            wdog_d   = wdog_q + 1'b1;
            wdog_hit = (wdog_q == WdW'(WdogCyc - 1));
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wdog_q <= '0;
        end else begin
            wdog_q <= wdog_d;
        end
    end
`else
    assign wdog_hit = 1'b0;
`endif

    always_comb begin
        state_d    = state_q;
        owner_d    = owner_q;
        owner_vc_d = owner_vc_q;
        rr_ptr_d   = rr_ptr_q;
        unique case (state_q)
            StIdle: begin
                if (xfer) begin
                    rr_ptr_d = (pick_idx == IdxW'(NumReq - 1)) ? '0 : pick_idx + 1'b1;
                    if (!xfer_tail) begin
                        owner_d    = pick_idx;
                        owner_vc_d = xfer_vc;
                        state_d    = StLocked;
                    end
                end
            end
            StLocked: begin
                if ((xfer && xfer_tail) || wdog_hit) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        for (int unsigned v = 0; v < NumVc; v++) begin
            cr_inc[v] = flow_ctrl_i[FC_VALID_BIT] && (flow_ctrl_i[FC_VC_BIT] == 1'(v));
            cr_dec[v] = xfer && (xfer_vc == 1'(v));
        end
    end

    // A simultaneous return and consume on one VC leaves the count untouched.
    always_comb begin
        credit_d = credit_q;
        overflow = 1'b0;
        for (int unsigned v = 0; v < NumVc; v++) begin
            if (cr_inc[v] && !cr_dec[v]) begin
                if (credit_q[v] == CW'(BufDepth)) begin
                    overflow = 1'b1;
                end else begin
                    credit_d[v] = credit_q[v] + 1'b1;
                end
            end else if (cr_dec[v] && !cr_inc[v]) begin
                credit_d[v] = credit_q[v] - 1'b1;
            end
        end
    end

    always_comb begin
        chan_d  = xfer ? {1'b1, xfer_head, xfer_tail, xfer_vc,
                          req_data_i[xfer_idx*DataW +: DataW]} : '0;
        error_d = error_q | overflow | wdog_hit | (state_q == StLocked && xfer && xfer_head);
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            owner_q    <= '0;
            owner_vc_q <= 1'b0;
            rr_ptr_q   <= '0;
            credit_q   <= {NumVc{CW'(BufDepth)}};
            chan_q     <= '0;
            error_q    <= 1'b0;
        end else begin
            owner_q    <= owner_d;
            owner_vc_q <= owner_vc_d;
            rr_ptr_q   <= rr_ptr_d;
            credit_q   <= credit_d;
            chan_q     <= chan_d;
            error_q    <= error_d;
        end
    end

    assign channel_out_o = chan_q;
    assign error_o       = error_q;

endmodule

// File: tb/tb_router_inject_arbiter.sv
// Directed bench for router_inject_arbiter: arbitration order, packet locking, credits,
// overflow error and asynchronous reset.
module tb_router_inject_arbiter;

    logic         clk;
    logic         reset;
    logic [3:0]   req_valid, req_head, req_tail, req_vc;
    logic [255:0] req_data;
    logic [3:0]   req_ready;
    logic [67:0]  channel_out;
    logic [1:0]   flow_ctrl;
    logic         error;

    int n_checks = 0;
    int n_errors = 0;

    router_inject_arbiter u_dut (
        .clk           (clk),
        .reset         (reset),
        .req_valid_i   (req_valid),
        .req_head_i    (req_head),
        .req_tail_i    (req_tail),
        .req_vc_i      (req_vc),
        .req_data_i    (req_data),
        .req_ready_o   (req_ready),
        .channel_out_o (channel_out),
        .flow_ctrl_i   (flow_ctrl),
        .error_o       (error)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not reach the end");
        $fatal(1, "timeout");
    end

    task automatic chk(input string tag, input logic [67:0] got, input logic [67:0] exp);
        n_checks++;
        assert (got === exp) else begin
            n_errors++;
            $error("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic logic [67:0] flit(input logic h, input logic t, input logic vc,
                                          input logic [63:0] d);
        return {1'b1, h, t, vc, d};
    endfunction

    task automatic put(input int i, input logic v, input logic h, input logic t,
                       input logic vc, input logic [63:0] d);
        req_valid[i]         = v;
        req_head[i]          = h;
        req_tail[i]          = t;
        req_vc[i]            = vc;
        req_data[i*64 +: 64] = d;
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        reset     = 1'b1;
        req_valid = '0;
        req_head  = '0;
        req_tail  = '0;
        req_vc    = '0;
        req_data  = '0;
        flow_ctrl = '0;
        put(0, 1, 1, 1, 0, 64'h1);
        #2;
        chk("reset_channel", channel_out, 68'h0);
        chk("reset_ready", {64'h0, req_ready}, 68'h0);
        chk("reset_error", {67'h0, error}, 68'h0);
        step();
        reset = 1'b0;

        // Four single-flit heads on VC0: round-robin grants 0,1,2,3 back to back.
        for (int i = 0; i < 4; i++) put(i, 1, 1, 1, 0, 64'h100 + 64'(i));
        for (int i = 0; i < 4; i++) begin
            #1;
            chk("rr_ready", {64'h0, req_ready}, 68'(4'b0001 << i));
            step();
            req_valid[i] = 1'b0;
            chk("rr_channel", channel_out, flit(1, 1, 0, 64'h100 + 64'(i)));
        end
        #1;
        chk("idle_ready", {64'h0, req_ready}, 68'h0);
        step();
        chk("idle_channel", channel_out, 68'h0);

        // Req1 three-flit packet on VC1 while req2 holds a head; req2 waits for the tail.
        put(1, 1, 1, 0, 1, 64'h200);
        put(2, 1, 1, 1, 0, 64'h2F0);
        #1;
        chk("pkt_head_ready", {64'h0, req_ready}, 68'h2);
        step();
        chk("pkt_head_chan", channel_out, flit(1, 0, 1, 64'h200));
        put(1, 1, 0, 0, 0, 64'h201);
        #1;
        chk("pkt_body_ready", {64'h0, req_ready}, 68'h2);
        step();
        chk("pkt_body_chan", channel_out, flit(0, 0, 1, 64'h201));
        put(1, 1, 0, 1, 0, 64'h202);
        #1;
        chk("pkt_tail_ready", {64'h0, req_ready}, 68'h2);
        step();
        chk("pkt_tail_chan", channel_out, flit(0, 1, 1, 64'h202));
        req_valid[1] = 1'b0;
        #1;
        chk("pkt_next_ready", {64'h0, req_ready}, 68'h4);
        step();
        chk("pkt_next_chan", channel_out, flit(1, 1, 0, 64'h2F0));
        req_valid[2] = 1'b0;

        // VC0=3, VC1=5: top VC1 back up to 8.
        flow_ctrl = 2'b11;
        step();
        step();
        step();
        flow_ctrl = 2'b00;

        // Drain all eight VC1 credits.
        for (int k = 0; k < 8; k++) begin
            put(0, 1, 1, 1, 1, 64'h300 + 64'(k));
            #1;
            chk("vc1_ready", {64'h0, req_ready}, 68'h1);
            step();
            chk("vc1_chan", channel_out, flit(1, 1, 1, 64'h300 + 64'(k)));
        end
        put(0, 1, 1, 1, 1, 64'h308);
        put(3, 1, 1, 1, 0, 64'h400);
        flow_ctrl = 2'b10;
        #1;
        chk("vc1_block_vc0_ok", {64'h0, req_ready}, 68'h8);
        step();
        chk("vc0_chan", channel_out, flit(1, 1, 0, 64'h400));
        req_valid[3] = 1'b0;
        flow_ctrl = 2'b11;
        #1;
        chk("vc1_still_stalled", {64'h0, req_ready}, 68'h0);
        step();
        flow_ctrl = 2'b00;
        #1;
        chk("vc1_released", {64'h0, req_ready}, 68'h1);
        step();
        chk("vc1_released_chan", channel_out, flit(1, 1, 1, 64'h308));
        req_valid[0] = 1'b0;

        // VC0 should still hold exactly 3 credits after the simultaneous return/consume.
        for (int k = 0; k < 3; k++) begin
            put(3, 1, 1, 1, 0, 64'h500 + 64'(k));
            #1;
            chk("vc0_three_ready", {64'h0, req_ready}, 68'h8);
            step();
        end
        #1;
        chk("vc0_exhausted", {64'h0, req_ready}, 68'h0);
        req_valid[3] = 1'b0;
        chk("no_error_yet", {67'h0, error}, 68'h0);

        // Eight returns refill VC0; the ninth overflows.
        flow_ctrl = 2'b10;
        repeat (8) step();
        chk("refill_no_error", {67'h0, error}, 68'h0);
        step();
        flow_ctrl = 2'b00;
        chk("overflow_error", {67'h0, error}, 68'h1);
        for (int k = 0; k < 8; k++) begin
            put(2, 1, 1, 1, 0, 64'h600 + 64'(k));
            #1;
            chk("sat_ready", {64'h0, req_ready}, 68'h4);
            step();
        end
        #1;
        chk("sat_stays_8", {64'h0, req_ready}, 68'h0);
        req_valid[2] = 1'b0;
        chk("error_sticky", {67'h0, error}, 68'h1);

        // Reset in the middle of a locked packet.
        flow_ctrl = 2'b11;
        step();
        step();
        flow_ctrl = 2'b00;
        put(1, 1, 1, 0, 1, 64'h700);
        #1;
        chk("lock_head_ready", {64'h0, req_ready}, 68'h2);
        step();
        chk("lock_head_chan", channel_out, flit(1, 0, 1, 64'h700));
        put(1, 1, 0, 0, 1, 64'h701);
        #1;
        chk("lock_body_ready", {64'h0, req_ready}, 68'h2);
        reset = 1'b1;
        #1;
        chk("async_rst_chan", channel_out, 68'h0);
        chk("async_rst_ready", {64'h0, req_ready}, 68'h0);
        chk("async_rst_error", {67'h0, error}, 68'h0);
        step();
        reset = 1'b0;
        #1;
        chk("idle_body_ignored", {64'h0, req_ready}, 68'h0);
        for (int k = 0; k < 8; k++) begin
            put(1, 1, 1, 1, 1, 64'h800 + 64'(k));
            #1;
            chk("post_rst_ready", {64'h0, req_ready}, 68'h2);
            step();
            chk("post_rst_chan", channel_out, flit(1, 1, 1, 64'h800 + 64'(k)));
        end
        #1;
        chk("post_rst_credit8", {64'h0, req_ready}, 68'h0);
        req_valid[1] = 1'b0;

        // A head from the owner while locked is forwarded and flags an error.
        put(0, 1, 1, 0, 0, 64'h900);
        #1;
        chk("hl_first_ready", {64'h0, req_ready}, 68'h1);
        step();
        chk("hl_first_no_err", {67'h0, error}, 68'h0);
        put(0, 1, 1, 0, 0, 64'h901);
        #1;
        chk("hl_second_ready", {64'h0, req_ready}, 68'h1);
        step();
        chk("hl_error", {67'h0, error}, 68'h1);
        chk("hl_chan", channel_out, flit(1, 0, 0, 64'h901));
        put(0, 1, 0, 1, 1, 64'h902);
        put(1, 1, 1, 1, 0, 64'hA00);
        #1;
        chk("hl_tail_ready", {64'h0, req_ready}, 68'h1);
        step();
        chk("hl_tail_chan", channel_out, flit(0, 1, 0, 64'h902));
        req_valid[0] = 1'b0;
        #1;
        chk("hl_back_idle", {64'h0, req_ready}, 68'h2);
        step();
        chk("hl_next_chan", channel_out, flit(1, 1, 0, 64'hA00));

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
